// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS stopwatch controller.
// The blank-pair helper keeps the adjust-mode blink mask in one place.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJ    = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

  // bit3 = min_tens ... bit0 = sec_ones; sel=1 selects the seconds pair
  function automatic logic [3:0] blank_pair(input logic sel);
    logic [3:0] mask;
    if (sel) begin
      mask = 4'b0011;
    end else begin
      mask = 4'b1100;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with increment, synchronous clear and carry-out.
// Out-of-range digits (never produced) are treated as their maximum so they wrap.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               co
);

  logic [DIGIT_W-1:0] tens_d, tens_q;
  logic [DIGIT_W-1:0] ones_d, ones_q;
  logic               at_max_s;

  // Next digit values; clear dominates increment
  always_comb begin
    tens_d   = tens_q;
    ones_d   = ones_q;
    at_max_s = (tens_q >= TENS_MAX) && (ones_q >= ONES_MAX);
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (ones_q >= ONES_MAX) begin
        ones_d = 4'd0;
        if (tens_q >= TENS_MAX) begin
          tens_d = 4'd0;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  // Digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign co   = inc & at_max_s;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for a 4-digit MM:SS stopwatch: second and adjust
// dividers, state machine, BCD time registers and adjust-mode blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int ADJ_DIV  = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_p,
  input  logic               clear_p,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [3:0]         blank,
  output logic               running
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int ADJ_W  = $clog2(ADJ_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_DIV - 1);
  localparam logic [ADJ_W-1:0]  ADJ_ONE   = ADJ_W'(1);
  localparam logic [ADJ_W-1:0]  ADJ_ZERO  = {ADJ_W{1'b0}};

  state_e            state_d, state_q;
  logic [TICK_W-1:0] tick_cnt_d, tick_cnt_q;
  logic [ADJ_W-1:0]  adj_cnt_d, adj_cnt_q;
  logic              blink_d, blink_q;
  logic [3:0]        blank_d, blank_q;
  logic              running_d, running_q;

  logic in_run_s, in_adj_s, adj_entry_s;
  logic sec_tick_s, adj_tick_s;
  logic sec_inc_s, min_inc_s, sec_co_s, min_co_unused_s;

  // Next state; adj overrides everything, pause_p only toggles PAUSED/RUN
  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ADJ;
    end else begin
      case (state_q)
        ADJ:     state_d = PAUSED;
        PAUSED:  state_d = pause_p ? RUN : PAUSED;
        RUN:     state_d = pause_p ? PAUSED : RUN;
        default: state_d = PAUSED;
      endcase
    end
  end

  // Dividers, blink phase and registered output decode
  always_comb begin
    in_run_s    = (state_q == RUN);
    in_adj_s    = (state_q == ADJ);
    adj_entry_s = (state_d == ADJ) && !in_adj_s;
    sec_tick_s  = in_run_s && (tick_cnt_q == TICK_LAST);
    adj_tick_s  = in_adj_s && (adj_cnt_q == ADJ_LAST);

    // The second divider holds outside RUN so a resume keeps the partial second
    tick_cnt_d = tick_cnt_q;
    if (clear_p || sec_tick_s) begin
      tick_cnt_d = TICK_ZERO;
    end else if (in_run_s) begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    adj_cnt_d = adj_cnt_q;
    blink_d   = blink_q;
    if (adj_entry_s) begin
      adj_cnt_d = ADJ_ZERO;
      blink_d   = 1'b0;
    end else if (adj_tick_s) begin
      adj_cnt_d = ADJ_ZERO;
      blink_d   = ~blink_q;
    end else if (in_adj_s) begin
      adj_cnt_d = adj_cnt_q + ADJ_ONE;
    end else begin
      adj_cnt_d = adj_cnt_q;
    end

    // Decoded from next-state values so blank and running line up with state_q
    if ((state_d == ADJ) && blink_d) begin
      blank_d = blank_pair(sel);
    end else begin
      blank_d = 4'b0000;
    end
    running_d = (state_d == RUN);

    sec_inc_s = sec_tick_s | (adj_tick_s & sel);
    min_inc_s = (in_run_s & sec_co_s) | (adj_tick_s & ~sel);
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAUSED;
      tick_cnt_q <= TICK_ZERO;
      adj_cnt_q  <= ADJ_ZERO;
      blink_q    <= 1'b0;
      blank_q    <= 4'b0000;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      adj_cnt_q  <= adj_cnt_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
      running_q  <= running_d;
    end
  end

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc_s),
    .clr   (clear_p),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .co    (sec_co_s)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc_s),
    .clr   (clear_p),
    .tens  (min_tens),
    .ones  (min_ones),
    .co    (min_co_unused_s)
  );

  assign blank   = blank_q;
  assign running = running_q;

endmodule
